// File: rtl/rdft_pkg.sv
// Shared constants and types for the 106-point RDFT input reorder buffer.
// Frame is 2 x 53 samples; read FSM has two states.
package rdft_pkg;

  localparam int WIDTH_DEF = 64;
  localparam int N2_DEF    = 53;
  localparam int N_DEF     = 2 * N2_DEF;
  localparam int PTR_W     = $clog2(N_DEF);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

endpackage

// File: rtl/rdft_frame_bank.sv
// One frame bank: 1 write port, 2 registered read ports.
// Ports: clk, reset (async low), we/waddr/wdata, re/raddr0/raddr1, rdata0/rdata1.
module rdft_frame_bank
  import rdft_pkg::*;
#(
  parameter int DW    = 2 * WIDTH_DEF,
  parameter int DEPTH = N_DEF,
  parameter int AW    = PTR_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr0,
  input  logic [AW-1:0] raddr1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read registers only move on re, so a stalled pair stays put.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata0 <= '0;
      rdata1 <= '0;
    end else if (re) begin
      rdata0 <= mem[raddr0];
      rdata1 <= mem[raddr1];
    end
  end

endmodule

// File: rtl/rdft_input_reorder.sv
// Ping-pong buffer: natural-order input, Good-Thomas pair-order output.
// Ports: clk, reset (async low), in_valid/in_ready/in_re/in_im,
//        out_valid/out_ready/out_re0/out_im0/out_re1/out_im1/out_last.
module rdft_input_reorder
  import rdft_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int N2    = N2_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_re,
  input  logic [WIDTH-1:0] in_im,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_re0,
  output logic [WIDTH-1:0] out_im0,
  output logic [WIDTH-1:0] out_re1,
  output logic [WIDTH-1:0] out_im1,
  output logic             out_last
);

  localparam int N  = 2 * N2;
  localparam int AW = $clog2(N);
  localparam int DW = 2 * WIDTH;

  localparam logic [AW-1:0] LAST_W = AW'(N - 1);
  localparam logic [AW-1:0] LAST_P = AW'(N2 - 1);
  localparam logic [AW-1:0] A1_0   = AW'(N2);
  localparam logic [AW:0]   NW     = (AW + 1)'(N);

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr;
  logic          wr_bank;
  logic          rd_bank, rd_bank_d;
  logic [1:0]    full;
  logic [AW-1:0] n2_q, n2_d;
  logic [AW-1:0] a0_q, a0_d;
  logic [AW-1:0] a1_q, a1_d;
  logic [AW:0]   a1_inc;
  logic [AW-1:0] a1_nx;
  logic          ld, ld_bank, clr;
  logic          out_sel;
  logic          wr_fire;
  logic [DW-1:0] q0 [2];
  logic [DW-1:0] q1 [2];

  // A bank freed this cycle is writable in the same cycle.
  assign in_ready  = !full[wr_bank] || (clr && (rd_bank == wr_bank));
  assign wr_fire   = in_valid && in_ready;
  assign out_valid = (state_q == STREAM);
  assign out_last  = out_valid && (n2_q == LAST_P);

  // a1 walks 53,55,..,105,1,3,..: add 2, wrap once past N.
  assign a1_inc = {1'b0, a1_q} + (AW + 1)'(2);
  assign a1_nx  = (a1_inc >= NW) ? AW'(a1_inc - NW)
                                 : a1_inc[AW-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      wr_bank <= 1'b0;
      full    <= '0;
    end else begin
      if (clr) full[rd_bank] <= 1'b0;
      if (wr_fire) begin
        if (wr_ptr == LAST_W) begin
          wr_ptr        <= '0;
          wr_bank       <= ~wr_bank;
          full[wr_bank] <= 1'b1;
        end else begin
          wr_ptr <= wr_ptr + AW'(1);
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    n2_d      = n2_q;
    a0_d      = a0_q;
    a1_d      = a1_q;
    rd_bank_d = rd_bank;
    ld        = 1'b0;
    ld_bank   = rd_bank;
    clr       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (full[rd_bank]) begin
          ld      = 1'b1;
          n2_d    = '0;
          a0_d    = '0;
          a1_d    = A1_0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (n2_q == LAST_P) begin
            clr       = 1'b1;
            rd_bank_d = ~rd_bank;
            ld_bank   = ~rd_bank;
            if (full[~rd_bank]) begin
              ld   = 1'b1;
              n2_d = '0;
              a0_d = '0;
              a1_d = A1_0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            ld   = 1'b1;
            n2_d = n2_q + AW'(1);
            a0_d = a0_q + AW'(2);
            a1_d = a1_nx;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rd_bank <= 1'b0;
      n2_q    <= '0;
      a0_q    <= '0;
      a1_q    <= A1_0;
      out_sel <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_bank <= rd_bank_d;
      n2_q    <= n2_d;
      a0_q    <= a0_d;
      a1_q    <= a1_d;
      if (ld) out_sel <= ld_bank;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    rdft_frame_bank #(
      .DW   (DW),
      .DEPTH(N),
      .AW   (AW)
    ) u_bank (
      .clk   (clk),
      .reset (reset),
      .we    (wr_fire && (wr_bank == 1'(b))),
      .waddr (wr_ptr),
      .wdata ({in_re, in_im}),
      .re    (ld && (ld_bank == 1'(b))),
      .raddr0(a0_d),
      .raddr1(a1_d),
      .rdata0(q0[b]),
      .rdata1(q1[b])
    );
  end

  assign {out_re0, out_im0} = q0[out_sel];
  assign {out_re1, out_im1} = q1[out_sel];

endmodule

// File: tb/tb_rdft_input_reorder.sv
// Scoreboard bench for rdft_input_reorder.
// Driver pushes expected pairs per completed frame; monitor pops.
module tb_rdft_input_reorder;

  typedef struct packed {
    logic [63:0] re0;
    logic [63:0] im0;
    logic [63:0] re1;
    logic [63:0] im1;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_re = '0;
  logic [63:0] in_im = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_re0, out_im0;
  logic [63:0] out_re1, out_im1;
  logic        out_last;

  int tests = 0;
  int fails = 0;
  int stalls = 0;
  int sent = 0;
  int widx = 0;
  int lasts = 0;
  logic tog_en = 1'b0;

  logic [63:0] smp_re [106];
  logic [63:0] smp_im [106];
  exp_t expq [$];
  exp_t gotq [$];

  rdft_input_reorder dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_re    (in_re),
    .in_im    (in_im),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_re0  (out_re0),
    .out_im0  (out_im0),
    .out_re1  (out_re1),
    .out_im1  (out_im1),
    .out_last (out_last)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (tog_en) out_ready = ~out_ready;

  task automatic chk(input string nm, input logic [256:0] got,
                     input logic [256:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  task automatic put(input logic [63:0] re, input logic [63:0] im);
    int g;
    exp_t e;
    int a1;
    @(negedge clk);
    in_valid = 1'b1;
    in_re = re;
    in_im = im;
    #1;
    g = 0;
    while (!in_ready && g < 2000) begin
      @(negedge clk);
      #1;
      g++;
      stalls++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL put_timeout: in_ready got 0 want 1");
    end
    @(posedge clk);
    smp_re[widx] = re;
    smp_im[widx] = im;
    sent++;
    if (widx == 105) begin
      widx = 0;
      for (int n = 0; n < 53; n++) begin
        a1 = (53 + 2 * n) % 106;
        e.re0 = smp_re[2*n];
        e.im0 = smp_im[2*n];
        e.re1 = smp_re[a1];
        e.im1 = smp_im[a1];
        e.last = (n == 52);
        expq.push_back(e);
      end
    end else begin
      widx++;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((expq.size() != 0 || out_valid) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 3000) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d pairs left want 0",
               expq.size());
    end
    repeat (3) @(negedge clk);
  endtask

  // Monitor: transfer check + hold-stable check on stalls.
  initial begin : monitor
    exp_t cur;
    exp_t saved;
    exp_t e;
    logic held;
    held = 1'b0;
    saved = '0;
    forever begin
      @(negedge clk);
      #2;
      cur = '{out_re0, out_im0, out_re1, out_im1, out_last};
      if (reset && out_valid) begin
        if (held) chk("hold", cur, saved);
        if (out_ready) begin
          if (expq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_pair: got %0h want none", cur);
          end else begin
            e = expq.pop_front();
            chk("pair", cur, e);
          end
          gotq.push_back(cur);
          if (out_last) lasts++;
        end
        held = !out_ready;
        saved = cur;
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin : main
    int g;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_re0", out_re0, 0);
    @(negedge clk);
    reset = 1'b1;

    // T1: single ramp, latency and hand-computed pairs
    gotq.delete();
    lasts = 0;
    for (int k = 0; k < 106; k++) put(64'(k * 1000000), 0);
    idle();
    #1;
    chk("lat_early", out_valid, 0);
    @(negedge clk);
    #1;
    chk("lat_first", out_valid, 1);
    drain();
    chk("t1_count", gotq.size(), 53);
    chk("t1_lasts", lasts, 1);
    chk("t1_p0", {gotq[0].re0, gotq[0].re1}, {64'd0, 64'd53000000});
    chk("t1_p1", {gotq[1].re0, gotq[1].re1},
        {64'd2000000, 64'd55000000});
    chk("t1_p26", {gotq[26].re0, gotq[26].re1},
        {64'd52000000, 64'd105000000});
    chk("t1_p27", {gotq[27].re0, gotq[27].re1},
        {64'd54000000, 64'd1000000});
    chk("t1_p52", {gotq[52].re0, gotq[52].re1, gotq[52].last},
        {64'd104000000, 64'd51000000, 1'b1});

    // T2: two back-to-back frames, in_ready never drops
    gotq.delete();
    stalls = 0;
    for (int f = 0; f < 2; f++)
      for (int k = 0; k < 106; k++)
        put(64'(f * 200000000 + k * 1000000), 0);
    idle();
    chk("t2_stalls", stalls, 0);
    drain();
    chk("t2_count", gotq.size(), 106);
    chk("t2_p53", {gotq[53].re0, gotq[53].re1},
        {64'd200000000, 64'd253000000});

    // T3: backpressure while 2.5 frames are offered
    gotq.delete();
    sent = 0;
    @(negedge clk);
    out_ready = 1'b0;
    fork
      begin
        for (int f = 0; f < 3; f++)
          for (int k = 0; k < 106; k++)
            if (f < 2 || k < 53)
              put(64'(1000 * (f + 1) + k), 64'(50000 + k));
      end
      begin
        g = 0;
        while (sent < 212 && g < 5000) begin
          @(negedge clk);
          g++;
        end
        #1;
        chk("t3_in_ready_low", in_ready, 0);
        chk("t3_hold_valid", out_valid, 1);
        chk("t3_hold_n2_0", {out_re0, out_re1}, {64'd1000, 64'd1053});
        repeat (60) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    for (int k = 53; k < 106; k++) put(64'(3000 + k), 64'(50000 + k));
    idle();
    drain();
    chk("t3_count", gotq.size(), 159);
    chk("t3_p53", {gotq[53].re0, gotq[53].re1}, {64'd2000, 64'd2053});

    // T4: imaginary path
    gotq.delete();
    for (int k = 0; k < 106; k++) put(0, 64'(7 * k));
    idle();
    drain();
    chk("t4_p27_im", {gotq[27].im0, gotq[27].im1}, {64'd378, 64'd7});
    chk("t4_p0_im", {gotq[0].im0, gotq[0].im1}, {64'd0, 64'd371});

    // T5: reset mid-frame discards the partial frame
    gotq.delete();
    for (int k = 0; k < 40; k++) put(64'(999000 + k), 0);
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b0;
    widx = 0;
    #1;
    chk("t5_rst_ready", in_ready, 1);
    chk("t5_rst_valid", out_valid, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("t5_no_partial", gotq.size(), 0);
    for (int k = 0; k < 106; k++) put(64'(k * 1000000), 0);
    idle();
    drain();
    chk("t5_count", gotq.size(), 53);
    chk("t5_p27", {gotq[27].re0, gotq[27].re1},
        {64'd54000000, 64'd1000000});

    // T6: out_ready toggling every cycle
    gotq.delete();
    lasts = 0;
    tog_en = 1'b1;
    for (int k = 0; k < 106; k++) put(64'(5000 + k), 64'(k));
    idle();
    drain();
    tog_en = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    chk("t6_count", gotq.size(), 53);
    chk("t6_lasts", lasts, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rdft_input_reorder.md
Name: rdft_input_reorder

Overview:
- Ping-pong input frame buffer placed directly upstream of the 106-point RDFT (2 x 53 prime-factor decomposition).
- Accepts one complex sample per cycle in natural order 0..105.
- Emits each frame as 53 sample pairs in Good-Thomas input order, so the 53-point stage gets its two complex inputs (data1/j_data1, data2/j_data2) together.
- Two banks, so the next frame can be written while the previous one streams out.

Parameters:
- WIDTH, 64, bit width of each real and each imaginary component
- N2, 53, inner transform length; frame length N = 2*N2 = 106 (derived, not overridable)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  input sample present
- in_ready  out  1  block can accept a sample
- in_re  in  WIDTH  real part of sample
- in_im  in  WIDTH  imaginary part of sample
- out_valid  out  1  output pair present
- out_ready  in  1  downstream accepts pair
- out_re0  out  WIDTH  real of first pair element (n1=0)
- out_im0  out  WIDTH  imaginary of first pair element
- out_re1  out  WIDTH  real of second pair element (n1=1)
- out_im1  out  WIDTH  imaginary of second pair element
- out_last  out  1  final pair (n2=52) of a frame

Behaviour:
- Reset (reset=0, async):
  - both banks empty; write bank 0; read bank 0; state IDLE
  - in_ready=1; out_valid=0; out_last=0; out_re/im*=0
  - a partially written frame is discarded; buffer contents need not be cleared
- Write side:
  - transfer when in_valid & in_ready; stored at wr_ptr in the current write bank; wr_ptr increments
  - at wr_ptr=105: bank marked full, wr_ptr->0, write bank toggles
  - in_ready = !full[write bank]
- Read FSM:
  - IDLE: when full[read bank], load n2=0, a0=0, a1=53; go to STREAM
  - STREAM: out_valid=1 with registered pair: element 0 = bank[a0], element 1 = bank[a1]
  - index mapping: a0 = 2*n2; a1 = (53 + 2*n2) mod 106, computed incrementally as a1+2, minus 106 when >=106, so no divider
  - on out_valid & out_ready: n2++
  - at n2=52 (out_last=1) accepted: clear full[read bank], toggle read bank; go back-to-back to STREAM if the other bank is full, else IDLE
  - out_valid & !out_ready: all outputs held stable (standard valid/ready)
- Latency: first pair valid 1 cycle after the cycle the 106th sample is written; then 1 pair/cycle under out_ready=1.
- Throughput: a frame drains in 53 cycles, fills in 106, so without backpressure in_ready never drops.
- Simultaneous events:
  - a bank freed by the read side and written in the same cycle: the clear takes effect first, so in_ready is 1 that cycle
  - fill completion and read-bank toggle in the same cycle are independent
- Both banks full: in_ready=0 until the read side frees one; no sample is dropped or overwritten.
- Data: passed bit-exact; no arithmetic on samples.

Decomposition:
- Package rdft_pkg: WIDTH default, N2=53, N=106, pointer widths (7 bits), FSM state enum {IDLE, STREAM}.
- Sub-module rdft_frame_bank: single 106 x 2*WIDTH bank, one write port, two registered read ports; instantiated twice.
- Index generator and FSM live in the top.

Test Plan:
- Ramp in_re = k*1000000 for k=0..105, in_im=0, out_ready=1 -> pairs (0,53e6), (2e6,55e6), …, n2=26: (52e6,105e6), n2=27: (54e6,1e6), n2=52: (104e6,51e6) with out_last=1; first out_valid 1 cycle after the k=105 write.
- Two consecutive ramp frames (second offset +200e6), in_valid always 1 -> in_ready stays 1, frames stream back-to-back with no gap; second frame n2=0 gives (200e6,253e6).
- out_ready low for 60 cycles while 2.5 frames are offered -> in_ready drops after the 212th sample, outputs held stable at n2=0, no data loss after release.
- in_im = 7*k, in_re=0 -> imaginary outputs follow the same mapping: n2=27 gives (378, 7).
- reset pulsed low after 40 samples of a frame, then a full ramp -> no out_valid from the partial frame; the new frame reorders correctly from bank 0.
- out_ready toggling every cycle -> each pair presented until accepted; exactly 53 transfers per frame, out_last exactly once.
